// File: rtl/prog_uart_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prog_uart_loader
//  Purpose  : Serial program loader placed in front of the instruction and
//             data memories. Receives an 8N1 UART stream carrying a 4-byte
//             little-endian size header followed by the payload, and emits
//             32-bit word writes (dmem) and 128-bit line writes (imem).
//             Raises done once the whole image is written so the core can
//             leave program-loading reset.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1    system clock
//    reset_x  in   1    asynchronous active-low reset
//    rxd      in   1    UART receive line, idle high, asynchronous to clk
//    addr     out  32   byte address of the word being written
//                       (addr[12:4] is the imem line index)
//    data     out  128  line shift register, newest word in [127:96]
//    we_32    out  1    one-cycle pulse, data[127:96] valid at addr
//    we_128   out  1    one-cycle pulse, data[127:0] valid at line addr[12:4]
//    done     out  1    sticky, image fully written
//    err      out  1    sticky, framing error seen
// ============================================================================
module prog_uart_loader #(
   parameter int CLKS_PER_BIT = 868,
   parameter int MEM_BYTES    = 8192
) (
   input  logic         clk,
   input  logic         reset_x,
   input  logic         rxd,
   output logic [31:0]  addr,
   output logic [127:0] data,
   output logic         we_32,
   output logic         we_128,
   output logic         done,
   output logic         err
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int c_cnt_w  = $clog2(CLKS_PER_BIT);
   localparam int c_addr_w = $clog2(MEM_BYTES);
   localparam int c_rem_w  = c_addr_w + 1;

   localparam logic [c_cnt_w-1:0]  c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
   localparam logic [c_cnt_w-1:0]  c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_addr_w-1:0] c_addr_max  = c_addr_w'(MEM_BYTES - 4);
   localparam logic [c_addr_w-1:0] c_addr_step = c_addr_w'(4);
   localparam logic [c_rem_w-1:0]  c_rem_max   = c_rem_w'(MEM_BYTES);
   localparam logic [c_rem_w-1:0]  c_rem_one   = c_rem_w'(1);
   localparam logic [31:0]         c_mem_bytes = MEM_BYTES;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      LD_HDR  = 2'd0,
      LD_LOAD = 2'd1,
      LD_PAD  = 2'd2,
      LD_DONE = 2'd3
   } ld_state_t;

   // ------------------------------------------------------------------------
   // Declarations
   // ------------------------------------------------------------------------
   logic                r_rxd_meta;
   logic                r_rxd_sync;
   logic                r_rxd_prev;

   rx_state_t           r_rx_state;
   rx_state_t           w_rx_state_nxt;
   logic [c_cnt_w-1:0]  r_rx_cnt;
   logic [c_cnt_w-1:0]  w_rx_cnt_nxt;
   logic [2:0]          r_rx_idx;
   logic [2:0]          w_rx_idx_nxt;
   logic [7:0]          r_rx_shift;
   logic [7:0]          w_rx_shift_nxt;
   logic                w_byte_stb;
   logic                w_frame_err;

   ld_state_t           r_ld_state;
   ld_state_t           w_ld_state_nxt;
   logic [1:0]          r_byte_cnt;
   logic [23:0]         r_word;
   logic [c_rem_w-1:0]  r_remaining;
   logic [c_addr_w-1:0] r_addr;
   logic [127:0]        r_data;
   logic                r_we_32;
   logic                r_we_128;
   logic                r_done;
   logic                r_err;

   logic                w_in_stb;
   logic [7:0]          w_in_byte;
   logic                w_word_done;
   logic                w_line_end;
   logic [31:0]         w_full_word;
   logic [c_rem_w-1:0]  w_size_sat;
   logic                w_emit;
   logic                w_load_start;
   logic                w_done_set;

   // ------------------------------------------------------------------------
   // rxd synchronizer. r_rxd_prev gives the previous synchronized value for
   // start-edge detection. Reset to the idle level so that releasing reset
   // with the line idle does not look like a start bit.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_rxd_meta <= 1'b1;
         r_rxd_sync <= 1'b1;
         r_rxd_prev <= 1'b1;
      end else begin
         r_rxd_meta <= rxd;
         r_rxd_sync <= r_rxd_meta;
         r_rxd_prev <= r_rxd_sync;
      end
   end

   // ------------------------------------------------------------------------
   // UART receive FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_idx   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_state <= w_rx_state_nxt;
         r_rx_cnt   <= w_rx_cnt_nxt;
         r_rx_idx   <= w_rx_idx_nxt;
         r_rx_shift <= w_rx_shift_nxt;
      end
   end

   always_comb begin
      w_rx_state_nxt = r_rx_state;
      w_rx_cnt_nxt   = r_rx_cnt;
      w_rx_idx_nxt   = r_rx_idx;
      w_rx_shift_nxt = r_rx_shift;
      w_byte_stb     = 1'b0;
      w_frame_err    = 1'b0;

      case (r_rx_state)
         RX_IDLE: begin
            w_rx_cnt_nxt = '0;
            w_rx_idx_nxt = '0;
            if (r_rxd_prev && !r_rxd_sync) begin
               w_rx_state_nxt = RX_START;
            end
         end

         // Half a bit in, the line must still be low or it was a glitch.
         RX_START: begin
            if (r_rx_cnt == c_half_last) begin
               w_rx_cnt_nxt   = '0;
               w_rx_state_nxt = r_rxd_sync ? RX_IDLE : RX_DATA;
            end else begin
               w_rx_cnt_nxt = r_rx_cnt + 1'b1;
            end
         end

         // LSB arrives first, so shift in from the top.
         RX_DATA: begin
            if (r_rx_cnt == c_bit_last) begin
               w_rx_cnt_nxt   = '0;
               w_rx_shift_nxt = {r_rxd_sync, r_rx_shift[7:1]};
               w_rx_idx_nxt   = r_rx_idx + 3'd1;
               if (r_rx_idx == 3'd7) begin
                  w_rx_state_nxt = RX_STOP;
               end
            end else begin
               w_rx_cnt_nxt = r_rx_cnt + 1'b1;
            end
         end

         RX_STOP: begin
            if (r_rx_cnt == c_bit_last) begin
               w_rx_cnt_nxt   = '0;
               w_rx_state_nxt = RX_IDLE;
               if (r_rxd_sync) begin
                  w_byte_stb = 1'b1;
               end else begin
                  w_frame_err = 1'b1;
               end
            end else begin
               w_rx_cnt_nxt = r_rx_cnt + 1'b1;
            end
         end

         default: begin
            w_rx_state_nxt = RX_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Byte source for the assembler: received bytes while collecting the
   // header or payload, a free-running stream of zero bytes while padding
   // the last line, nothing once the image is complete.
   // ------------------------------------------------------------------------
   always_comb begin
      w_in_stb  = 1'b0;
      w_in_byte = r_rx_shift;
      case (r_ld_state)
         LD_HDR,
         LD_LOAD: w_in_stb = w_byte_stb;
         LD_PAD: begin
            w_in_stb  = 1'b1;
            w_in_byte = 8'h00;
         end
         default: w_in_stb = 1'b0;
      endcase
   end

   assign w_word_done = w_in_stb && (r_byte_cnt == 2'd3);
   assign w_full_word = {w_in_byte, r_word};
   assign w_line_end  = (r_addr[3:2] == 2'b11);
   assign w_size_sat  = (w_full_word > c_mem_bytes) ? c_rem_max
                                                     : w_full_word[c_rem_w-1:0];

   // ------------------------------------------------------------------------
   // Loader FSM
   // ------------------------------------------------------------------------
   always_comb begin
      w_ld_state_nxt = r_ld_state;
      w_emit         = 1'b0;
      w_load_start   = 1'b0;
      w_done_set     = 1'b0;

      case (r_ld_state)
         LD_HDR: begin
            if (w_word_done) begin
               w_load_start = 1'b1;
               if (w_size_sat == '0) begin
                  // Empty image: nothing to write, release immediately.
                  w_ld_state_nxt = LD_DONE;
                  w_done_set     = 1'b1;
               end else begin
                  w_ld_state_nxt = LD_LOAD;
               end
            end
         end

         LD_LOAD: begin
            if (w_in_stb) begin
               w_emit = w_word_done;
               if (r_remaining == c_rem_one) begin
                  w_ld_state_nxt = (w_word_done && w_line_end) ? LD_DONE : LD_PAD;
               end
            end
         end

         LD_PAD: begin
            w_emit = w_word_done;
            if (w_word_done && w_line_end) begin
               w_ld_state_nxt = LD_DONE;
            end
         end

         // Entered on the edge that registers the final we_128, so done
         // rises the cycle after that pulse.
         LD_DONE: begin
            w_done_set = 1'b1;
         end

         default: begin
            w_ld_state_nxt = LD_HDR;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_ld_state <= LD_HDR;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_ld_state <= w_ld_state_nxt;
         if (w_done_set) begin
            r_done <= 1'b1;
         end
         if (w_frame_err) begin
            r_err <= 1'b1;
         end
      end
   end

   // Byte assembly. A dropped (framing-error) byte never strobes, so the
   // counter holds and the next good byte lands in the same lane.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_byte_cnt <= '0;
         r_word     <= '0;
      end else if (w_in_stb) begin
         r_byte_cnt <= r_byte_cnt + 2'd1;
         case (r_byte_cnt)
            2'd0:    r_word[7:0]   <= w_in_byte;
            2'd1:    r_word[15:8]  <= w_in_byte;
            2'd2:    r_word[23:16] <= w_in_byte;
            default: r_word        <= r_word;
         endcase
      end
   end

   // Write path: data shifts in the completed word on the same edge that
   // raises we_32, so the pulse always sees the newest word in [127:96].
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_data   <= '0;
         r_we_32  <= 1'b0;
         r_we_128 <= 1'b0;
      end else begin
         r_we_32  <= w_emit;
         r_we_128 <= w_emit && w_line_end;
         if (w_emit) begin
            r_data <= {w_full_word, r_data[127:32]};
         end
      end
   end

   // Address and byte budget. The address moves on after the write pulse
   // and parks on the last word of the memory rather than wrapping.
   always_ff @(posedge clk or negedge reset_x) begin
      if (!reset_x) begin
         r_remaining <= '0;
         r_addr      <= '0;
      end else begin
         if (w_load_start) begin
            r_remaining <= w_size_sat;
         end else if ((r_ld_state == LD_LOAD) && w_in_stb) begin
            r_remaining <= r_remaining - c_rem_one;
         end

         if (w_load_start) begin
            r_addr <= '0;
         end else if (r_we_32 && (r_addr != c_addr_max)) begin
            r_addr <= r_addr + c_addr_step;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign addr   = {{(32 - c_addr_w){1'b0}}, r_addr};
   assign data   = r_data;
   assign we_32  = r_we_32;
   assign we_128 = r_we_128;
   assign done   = r_done;
   assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_uart_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_prog_uart_loader
//  Purpose  : Self-checking bench for prog_uart_loader. A full-size instance
//             and a 32-byte instance, both at 4 clocks per UART bit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_uart_loader;

   localparam int CPB = 4;

   typedef struct {
      logic [31:0]  addr;
      logic [31:0]  word;
      logic         w128;
      logic [127:0] line;
   } wr_t;

   logic         clk = 1'b0;
   logic         reset_x;
   logic         rxd;
   logic         rxd_s;

   logic [31:0]  addr,   addr_s;
   logic [127:0] data,   data_s;
   logic         we_32,  we_32_s;
   logic         we_128, we_128_s;
   logic         done,   done_s;
   logic         err,    err_s;

   int           n_vec  = 0;
   int           n_fail = 0;

   wr_t          q_wr[$];
   wr_t          exp_tab[16];

   int           n32_s      = 0;
   int           n128_s     = 0;
   logic [31:0]  max_addr_s = '0;
   logic [127:0] line_s     = '0;

   always #5 clk = ~clk;

   prog_uart_loader #(
      .CLKS_PER_BIT (CPB),
      .MEM_BYTES    (8192)
   ) dut (
      .clk     (clk),
      .reset_x (reset_x),
      .rxd     (rxd),
      .addr    (addr),
      .data    (data),
      .we_32   (we_32),
      .we_128  (we_128),
      .done    (done),
      .err     (err)
   );

   prog_uart_loader #(
      .CLKS_PER_BIT (CPB),
      .MEM_BYTES    (32)
   ) dut_s (
      .clk     (clk),
      .reset_x (reset_x),
      .rxd     (rxd_s),
      .addr    (addr_s),
      .data    (data_s),
      .we_32   (we_32_s),
      .we_128  (we_128_s),
      .done    (done_s),
      .err     (err_s)
   );

   // Write monitors, sampled on the falling edge.
   always @(negedge clk) begin
      if (we_32) begin
         q_wr.push_back('{addr, data[127:96], we_128, data});
      end
      if (we_32_s) begin
         n32_s++;
         if (addr_s > max_addr_s) max_addr_s = addr_s;
      end
      if (we_128_s) begin
         n128_s++;
         line_s = data_s;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input bit sel, input logic b);
      if (sel) rxd_s = b;
      else     rxd   = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_byte(input bit sel, input logic [7:0] b, input logic stop);
      send_bit(sel, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(sel, b[i]);
      send_bit(sel, stop);
   endtask

   task automatic send_frame(input bit sel, input logic [7:0] b);
      send_byte(sel, b, 1'b1);
      send_bit(sel, 1'b1);
   endtask

   task automatic send_hdr(input bit sel, input logic [31:0] size);
      for (int i = 0; i < 4; i++) send_frame(sel, size[8*i +: 8]);
   endtask

   task automatic do_reset();
      reset_x = 1'b0;
      repeat (3) @(negedge clk);
      reset_x = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic wait_done(input string name, input bit sel, input int limit);
      int n;
      n = 0;
      while (!(sel ? done_s : done) && (n < limit)) begin
         @(negedge clk);
         n++;
      end
      chk(name, sel ? done_s : done, 1);
   endtask

   task automatic check_writes(input int base, input int tb_idx, input string tag);
      chk({tag, " write count"}, q_wr.size() - base, 4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < q_wr.size()) begin
            chk($sformatf("%s wr%0d addr", tag, i), q_wr[base+i].addr, exp_tab[tb_idx+i].addr);
            chk($sformatf("%s wr%0d word", tag, i), q_wr[base+i].word, exp_tab[tb_idx+i].word);
            chk($sformatf("%s wr%0d we128", tag, i), q_wr[base+i].w128, exp_tab[tb_idx+i].w128);
            if (exp_tab[tb_idx+i].w128)
               chk($sformatf("%s wr%0d line", tag, i), q_wr[base+i].line, exp_tab[tb_idx+i].line);
         end
      end
   endtask

   initial begin
      int base;

      // Expected write sequences, four per scenario.
      exp_tab[0]  = '{32'd0,  32'h03020100, 1'b0, 128'd0};
      exp_tab[1]  = '{32'd4,  32'h07060504, 1'b0, 128'd0};
      exp_tab[2]  = '{32'd8,  32'h0B0A0908, 1'b0, 128'd0};
      exp_tab[3]  = '{32'd12, 32'h0F0E0D0C, 1'b1, 128'h0F0E0D0C_0B0A0908_07060504_03020100};
      exp_tab[4]  = '{32'd0,  32'h14131211, 1'b0, 128'd0};
      exp_tab[5]  = '{32'd4,  32'h00001615, 1'b0, 128'd0};
      exp_tab[6]  = '{32'd8,  32'h00000000, 1'b0, 128'd0};
      exp_tab[7]  = '{32'd12, 32'h00000000, 1'b1, 128'h00000000_00000000_00001615_14131211};
      exp_tab[8]  = '{32'd0,  32'hA4A3A2A1, 1'b0, 128'd0};
      exp_tab[9]  = '{32'd4,  32'hA8A7A6A5, 1'b0, 128'd0};
      exp_tab[10] = '{32'd8,  32'h00000000, 1'b0, 128'd0};
      exp_tab[11] = '{32'd12, 32'h00000000, 1'b1, 128'h00000000_00000000_A8A7A6A5_A4A3A2A1};
      exp_tab[12] = '{32'd0,  32'h88776655, 1'b0, 128'd0};
      exp_tab[13] = '{32'd4,  32'h00000000, 1'b0, 128'd0};
      exp_tab[14] = '{32'd8,  32'h00000000, 1'b0, 128'd0};
      exp_tab[15] = '{32'd12, 32'h00000000, 1'b1, 128'h00000000_00000000_00000000_88776655};

      reset_x = 1'b0;
      rxd     = 1'b1;
      rxd_s   = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset addr",   addr,   0);
      chk("reset data",   data,   0);
      chk("reset we_32",  we_32,  0);
      chk("reset we_128", we_128, 0);
      chk("reset done",   done,   0);
      chk("reset err",    err,    0);
      reset_x = 1'b1;
      repeat (4) @(negedge clk);

      // Full line: 16 bytes, exact write/done timing after the last byte.
      base = q_wr.size();
      send_hdr(0, 32'h00000010);
      for (int i = 0; i < 15; i++) send_frame(0, 8'(i));
      send_byte(0, 8'h0F, 1'b1);
      chk("t1 we_32 early", we_32, 0);
      @(negedge clk);
      chk("t1 we_32 pulse",  we_32,  1);
      chk("t1 we_128 pulse", we_128, 1);
      chk("t1 done early",   done,   0);
      @(negedge clk);
      chk("t1 done",       done,  1);
      chk("t1 we_32 end",  we_32, 0);
      send_bit(0, 1'b1);
      send_frame(0, 8'hAA);
      send_frame(0, 8'hBB);
      check_writes(base, 0, "t1");
      do_reset();

      // Partial tail padded with zero words.
      base = q_wr.size();
      send_hdr(0, 32'h00000006);
      for (int i = 0; i < 6; i++) send_frame(0, 8'(8'h11 + i));
      wait_done("t2 done", 0, 200);
      check_writes(base, 4, "t2");
      do_reset();

      // Empty image.
      base = q_wr.size();
      for (int i = 0; i < 3; i++) send_frame(0, 8'h00);
      send_byte(0, 8'h00, 1'b1);
      chk("t3 done early", done, 0);
      @(negedge clk);
      chk("t3 done", done, 1);
      send_bit(0, 1'b1);
      chk("t3 no writes", q_wr.size() - base, 0);
      do_reset();

      // Glitch and framing error in the middle of a word.
      base = q_wr.size();
      send_hdr(0, 32'h00000008);
      send_frame(0, 8'hA1);
      rxd = 1'b0;
      @(negedge clk);
      rxd = 1'b1;
      repeat (20) @(negedge clk);
      chk("t4 err after glitch", err, 0);
      send_byte(0, 8'hEE, 1'b0);
      send_bit(0, 1'b1);
      send_bit(0, 1'b1);
      chk("t4 err after bad stop", err, 1);
      for (int i = 2; i <= 8; i++) send_frame(0, 8'(8'hA0 + i));
      wait_done("t4 done", 0, 200);
      check_writes(base, 8, "t4");
      chk("t4 err sticky", err, 1);
      do_reset();

      // Reset in the middle of the payload, then a fresh image.
      send_hdr(0, 32'h00000010);
      for (int i = 0; i < 6; i++) send_frame(0, 8'(8'hC0 + i));
      send_byte(0, 8'hC6, 1'b0);
      send_bit(0, 1'b1);
      send_bit(0, 1'b1);
      chk("t5 addr before reset", addr, 4);
      chk("t5 err before reset",  err,  1);
      reset_x = 1'b0;
      #1;
      chk("t5 reset addr",   addr,   0);
      chk("t5 reset data",   data,   0);
      chk("t5 reset we_32",  we_32,  0);
      chk("t5 reset we_128", we_128, 0);
      chk("t5 reset done",   done,   0);
      chk("t5 reset err",    err,    0);
      repeat (3) @(negedge clk);
      reset_x = 1'b1;
      repeat (4) @(negedge clk);
      base = q_wr.size();
      send_hdr(0, 32'h00000004);
      send_frame(0, 8'h55);
      send_frame(0, 8'h66);
      send_frame(0, 8'h77);
      send_frame(0, 8'h88);
      wait_done("t5 done", 0, 200);
      check_writes(base, 12, "t5");

      // Saturation on the 32-byte instance: header asks for 64 bytes.
      send_hdr(1, 32'h00000040);
      for (int i = 0; i < 64; i++) send_frame(1, 8'(i));
      wait_done("t6 done", 1, 200);
      chk("t6 we_32 count",  n32_s,      8);
      chk("t6 we_128 count", n128_s,     2);
      chk("t6 max addr",     max_addr_s, 28);
      chk("t6 last line",    line_s,     128'h1F1E1D1C_1B1A1918_17161514_13121110);
      chk("t6 err",          err_s,      0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
